// File: rtl/avalon_seg7_if.sv
// Avalon-MM slave bus for the seven-segment controller register file.
interface avalon_seg7_if;
   logic [3:0]  avs_address;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic        avs_read;
   logic [31:0] avs_readdata;

   modport master (output avs_address, avs_write, avs_writedata, avs_read,
                   input  avs_readdata);
   modport slave  (input  avs_address, avs_write, avs_writedata, avs_read,
                   output avs_readdata);
endinterface

// File: rtl/avalon_seg7_ctrl.sv
// Avalon-MM seven-segment controller: NUM_DIGITS digits in hex-decode or
// raw-segment mode, per-digit blink and leading-zero blanking.
module avalon_seg7_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_HZ     = 50000000,
   parameter int BLINK_HZ   = 2,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   avalon_seg7_if.slave            avs,
   output logic [7*NUM_DIGITS-1:0] segments
);
   localparam int          N       = NUM_DIGITS;
   localparam logic [31:0] DIV_RST = 32'(CLK_HZ / (2 * BLINK_HZ) - 1);
   localparam bit          AL      = (ACTIVE_LOW != 0);

   logic              en, lzb;
   logic [N-1:0]      raw_mask, blink_mask;
   logic [31:0]       value, blink_div, blink_cnt;
   logic              blink_phase;
   logic [N-1:0][6:0] raw;
   logic [31:0]       rd_mux;
   logic [N-1:0][6:0] pat;   // active-high per digit, all-zero means blank
   logic              scan;
   logic              div_wr;

   assign div_wr = avs.avs_write && (avs.avs_address == 4'd2);

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   // Register file writes; unmapped addresses and out-of-range RAW slots are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en         <= 1'b1;
         lzb        <= 1'b0;
         raw_mask   <= '0;
         blink_mask <= '0;
         value      <= '0;
         blink_div  <= DIV_RST;
         raw        <= '0;
      end else if (avs.avs_write) begin
         case (avs.avs_address)
            4'd0: begin
               en         <= avs.avs_writedata[0];
               lzb        <= avs.avs_writedata[1];
               raw_mask   <= avs.avs_writedata[8 +: N];
               blink_mask <= avs.avs_writedata[16 +: N];
            end
            4'd1: value     <= avs.avs_writedata;
            4'd2: blink_div <= avs.avs_writedata;
            default: begin
               for (int i = 0; i < N; i++)
                  if (avs.avs_address == 4'(8 + i)) raw[i] <= avs.avs_writedata[6:0];
            end
         endcase
      end
   end

   // Blink timebase: phase flips every BLINK_DIV+1 cycles; a BLINK_DIV write restarts it visible.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (div_wr) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == blink_div) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 32'd1;
      end
   end

   // Read mux over the pre-write register state.
   always_comb begin
      rd_mux = '0;
      case (avs.avs_address)
         4'd0: begin
            rd_mux[0]       = en;
            rd_mux[1]       = lzb;
            rd_mux[8 +: N]  = raw_mask;
            rd_mux[16 +: N] = blink_mask;
         end
         4'd1: rd_mux = value;
         4'd2: rd_mux = blink_div;
         default: begin
            for (int i = 0; i < N; i++)
               if (avs.avs_address == 4'(8 + i)) rd_mux = {25'd0, raw[i]};
         end
      endcase
   end

   // Registered read data, held until the next read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             avs.avs_readdata <= '0;
      else if (avs.avs_read) avs.avs_readdata <= rd_mux;
   end

   // Per-digit pattern and blanking; lzb scan walks down from the top digit
   // and stops at the first raw-mode digit or nonzero nibble.
   always_comb begin
      pat  = '0;
      scan = lzb;
      for (int i = N - 1; i >= 0; i--) begin
         pat[i] = raw_mask[i] ? raw[i] : hex7(value[4*i +: 4]);
         if (!en || (blink_mask[i] && blink_phase)) pat[i] = '0;
         if (scan && (i != 0) && !raw_mask[i] && (value[4*i +: 4] == 4'd0)) pat[i] = '0;
         if (raw_mask[i] || (value[4*i +: 4] != 4'd0)) scan = 1'b0;
      end
   end

   // Output register applies the display polarity.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) segments <= {(7*N){AL}};
      else       segments <= AL ? ~pat : pat;
   end
endmodule

// File: tb/tb_avalon_seg7_ctrl.sv
// Randomized bench for avalon_seg7_ctrl against a register-map level model.
module tb_avalon_seg7_ctrl;
   localparam int          N       = 4;
   localparam logic [31:0] DIV_RST = 32'd12499999;
   localparam logic [6:0]  HEX_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [7*N-1:0] segments;
   int             checks = 0;
   int             errors = 0;
   bit             run_chk = 1'b0;

   avalon_seg7_if bus();

   avalon_seg7_ctrl #(.NUM_DIGITS(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .avs      (bus),
      .segments (segments)
   );

   always #5 clk = ~clk;

   // Reference state
   bit             m_en, m_lzb;
   logic [N-1:0]   m_rmask, m_bmask;
   logic [31:0]    m_value, m_div;
   logic [6:0]     m_raw [N];
   logic [63:0]    ticks;          // edges since last blink restart
   logic [7*N-1:0] exp_seg;
   logic [31:0]    exp_rd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit phase_now();
      logic [63:0] win;
      win = ticks / ({32'd0, m_div} + 64'd1);
      return win[0];
   endfunction

   function automatic logic [7*N-1:0] model_seg(input bit ph);
      logic [7*N-1:0] s;
      logic [6:0]     p;
      bit             lit, lead;
      s = '0;
      for (int i = 0; i < N; i++) begin
         p   = m_rmask[i] ? m_raw[i] : HEX_TAB[m_value[4*i +: 4]];
         lit = m_en && !(m_bmask[i] && ph);
         if (m_lzb && i > 0) begin
            // blanked only if this and every higher digit is a hex-mode zero
            lead = 1'b1;
            for (int j = i; j < N; j++)
               if (m_rmask[j] || m_value[4*j +: 4] != 4'd0) lead = 1'b0;
            if (lead) lit = 1'b0;
         end
         if (!lit) p = 7'h00;
         s[7*i +: 7] = ~p;
      end
      return s;
   endfunction

   function automatic logic [31:0] rd_model(input logic [3:0] a);
      logic [31:0] r;
      r = '0;
      if (a == 4'd0)      r = {12'h0, m_bmask, 4'h0, m_rmask, 6'h0, m_lzb, m_en};
      else if (a == 4'd1) r = m_value;
      else if (a == 4'd2) r = m_div;
      else if (a >= 4'd8 && int'(a) < 8 + N) r = {25'h0, m_raw[int'(a) - 8]};
      return r;
   endfunction

   // Model update: outputs reflect the state before this edge's writes.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_en <= 1'b1; m_lzb <= 1'b0; m_rmask <= '0; m_bmask <= '0;
         m_value <= '0; m_div <= DIV_RST; ticks <= '0;
         for (int i = 0; i < N; i++) m_raw[i] <= '0;
         exp_seg <= '1;
         exp_rd  <= '0;
      end else begin
         exp_seg <= model_seg(phase_now());
         if (bus.avs_read) exp_rd <= rd_model(bus.avs_address);
         ticks <= ticks + 64'd1;
         if (bus.avs_write) begin
            case (bus.avs_address)
               4'd0: begin
                  m_en    <= bus.avs_writedata[0];
                  m_lzb   <= bus.avs_writedata[1];
                  m_rmask <= bus.avs_writedata[8 +: N];
                  m_bmask <= bus.avs_writedata[16 +: N];
               end
               4'd1: m_value <= bus.avs_writedata;
               4'd2: begin m_div <= bus.avs_writedata; ticks <= '0; end
               default:
                  if (bus.avs_address >= 4'd8 && int'(bus.avs_address) < 8 + N)
                     m_raw[int'(bus.avs_address) - 8] <= bus.avs_writedata[6:0];
            endcase
         end
      end
   end

   // Every cycle: outputs against the model.
   always @(negedge clk) begin
      if (run_chk) begin
         chk("seg", {4'h0, segments}, {4'h0, exp_seg});
         chk("rdata", bus.avs_readdata, exp_rd);
      end
   end

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1; bus.avs_read = 1'b0;
      @(negedge clk);
      bus.avs_write = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.avs_address = a; bus.avs_read = 1'b1; bus.avs_write = 1'b0;
      @(negedge clk);
      bus.avs_read = 1'b0;
      d = bus.avs_readdata;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [3:0]  a;
      bus.avs_address = '0; bus.avs_write = 1'b0; bus.avs_writedata = '0; bus.avs_read = 1'b0;
      #1 reset = 1'b1;
      run_chk = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_seg", {4'h0, segments}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});

      wr(4'd1, 32'h0000_A5C3);
      @(negedge clk);
      chk("hex_a5c3", {4'h0, segments}, {4'h0, 7'h08, 7'h12, 7'h46, 7'h30});
      rd(4'd1, d);
      chk("rd_value", d, 32'h0000_A5C3);

      wr(4'd0, 32'd3);
      wr(4'd1, 32'h0000_0050);
      @(negedge clk);
      chk("lzb_0050", {4'h0, segments}, {4'h0, 7'h7F, 7'h7F, 7'h12, 7'h40});
      wr(4'd1, 32'h0);
      @(negedge clk);
      chk("lzb_zero", {4'h0, segments}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h40});

      wr(4'd0, 32'h0000_0201);
      wr(4'd9, 32'h49);
      @(negedge clk);
      chk("raw1", {4'h0, segments}, {4'h0, 7'h40, 7'h40, 7'h36, 7'h40});

      wr(4'd0, 32'h0001_0001);
      wr(4'd2, 32'd3);
      repeat (13) @(negedge clk);
      wr(4'd2, 32'd3);
      repeat (10) @(negedge clk);

      // Random traffic, including same-cycle read/write of one address.
      repeat (600) begin
         @(negedge clk);
         case ($urandom_range(0, 7))
            0: a = 4'd0;
            1: a = 4'd1;
            2: a = 4'd2;
            7: a = 4'($urandom_range(0, 15));
            default: a = 4'(8 + $urandom_range(0, N - 1));
         endcase
         d = $urandom;
         if (a == 4'd2) d = $urandom_range(0, 6);
         if (a == 4'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         bus.avs_address   = a;
         bus.avs_writedata = d;
         bus.avs_write     = ($urandom_range(0, 2) == 0);
         bus.avs_read      = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      bus.avs_write = 1'b0; bus.avs_read = 1'b0;

      // Reset in the middle of blinking.
      wr(4'd0, 32'h0001_0001);
      wr(4'd2, 32'd1);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1 chk("async_blank", {4'h0, segments}, {4'h0, {(7*N){1'b1}}});
      @(negedge clk);
      reset = 1'b0;
      rd(4'd0, d);
      chk("rst_ctrl", d, 32'd1);
      rd(4'd5, d);
      chk("rd_unmapped", d, 32'd0);
      repeat (3) @(negedge clk);

      run_chk = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
